// File: rtl/perceptron_ctrl.sv
// Perceptron sequencer: streams N weight/input pairs through a signed MAC,
// thresholds the sum into y, and rewrites every weight on a training miss.
module perceptron_ctrl #(
  parameter int                       N        = 64,
  parameter int                       ADDR_W   = 7,
  parameter int                       DW       = 16,
  parameter int                       ACC_W    = 40,
  parameter logic signed [ACC_W-1:0]  THRESH   = '0,
  parameter int                       LR_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              train,
  input  logic              label,
  output logic              busy,
  output logic              done,
  output logic              y,
  output logic              updated,
  output logic              w_ena,
  output logic              w_wr_rd,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DW-1:0]     w_wdata,
  input  logic [DW-1:0]     w_rdata,
  output logic              x_ena,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [DW-1:0]     x_rdata
);

  localparam int STAGES = 2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, DECIDE, UPD_RD, UPD_WR, DONE} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [2*DW-1:0]  prod;
  logic [STAGES:0]         vld_pipe;
  logic                    train_r, label_r, y_run;
  logic                    y_nx;

  // Update path: w +/- (x >>> LR_SHIFT) computed one bit wider, then clamped.
  logic signed [DW-1:0] x_sh;
  logic signed [DW:0]   w_ext, x_ext, upd_sum;
  logic [DW-1:0]        upd_sat;

  assign x_sh    = $signed(x_rdata) >>> LR_SHIFT;
  assign w_ext   = {w_rdata[DW-1], w_rdata};
  assign x_ext   = {x_sh[DW-1], x_sh};
  assign upd_sum = label_r ? w_ext + x_ext : w_ext - x_ext;

  always_comb begin
    upd_sat = upd_sum[DW-1:0];
    if (upd_sum[DW] != upd_sum[DW-1])
      upd_sat = upd_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  // Read data is only valid in UPD_WR, so write data comes straight off it.
  assign w_wdata = (state == UPD_WR) ? upd_sat : '0;
  assign y_nx    = (acc >= THRESH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      y        <= 1'b0;
      updated  <= 1'b0;
      w_ena    <= 1'b0;
      w_wr_rd  <= 1'b0;
      x_ena    <= 1'b0;
      w_addr   <= '0;
      x_addr   <= '0;
      acc      <= '0;
      cnt      <= '0;
      prod     <= '0;
      vld_pipe <= '0;
      train_r  <= 1'b0;
      label_r  <= 1'b0;
      y_run    <= 1'b0;
    end else begin
      // vld_pipe: [0] read issued, [1] data on rdata, [2] product registered
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[1]) prod <= $signed(w_rdata) * $signed(x_rdata);
      if (vld_pipe[2]) acc  <= acc + ACC_W'(prod);
      done <= 1'b0;

      case (state)
        IDLE: if (start) begin
          train_r     <= train;
          label_r     <= label;
          acc         <= '0;
          cnt         <= '0;
          w_ena       <= 1'b1;
          x_ena       <= 1'b1;
          w_wr_rd     <= 1'b0;
          w_addr      <= '0;
          x_addr      <= '0;
          vld_pipe[0] <= 1'b1;
          busy        <= 1'b1;
          state       <= MAC;
        end
        MAC: if (cnt == LAST) begin
          w_ena       <= 1'b0;
          x_ena       <= 1'b0;
          vld_pipe[0] <= 1'b0;
          state       <= DRAIN;
        end else begin
          cnt    <= cnt + 1'b1;
          w_addr <= cnt + 1'b1;
          x_addr <= cnt + 1'b1;
        end
        // The last product lands in acc on the edge where vld_pipe[1] is clear.
        DRAIN: if (!vld_pipe[1]) state <= DECIDE;
        DECIDE: begin
          y_run <= y_nx;
          if (train_r && (y_nx != label_r)) begin
            cnt     <= '0;
            w_ena   <= 1'b1;
            x_ena   <= 1'b1;
            w_wr_rd <= 1'b0;
            w_addr  <= '0;
            x_addr  <= '0;
            state   <= UPD_RD;
          end else begin
            y       <= y_nx;
            updated <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        UPD_RD: begin
          w_wr_rd <= 1'b1;
          x_ena   <= 1'b0;
          state   <= UPD_WR;
        end
        UPD_WR: if (cnt == LAST) begin
          w_ena   <= 1'b0;
          w_wr_rd <= 1'b0;
          y       <= y_run;
          updated <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= DONE;
        end else begin
          cnt     <= cnt + 1'b1;
          w_addr  <= cnt + 1'b1;
          x_addr  <= cnt + 1'b1;
          x_ena   <= 1'b1;
          w_wr_rd <= 1'b0;
          state   <= UPD_RD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Bench for perceptron_ctrl: behavioural weight/input memories, a model that
// queues expected writes and results at launch, and a negedge monitor.
module tb_perceptron_ctrl;
  localparam int N   = 64;
  localparam int AW  = 7;
  localparam int DW  = 16;
  localparam int LRS = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b1, train = 1'b0, label = 1'b0;
  logic busy, done, y, updated, w_ena, w_wr_rd, x_ena;
  logic [AW-1:0] w_addr, x_addr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata = '0, x_rdata = '0;

  perceptron_ctrl #(.N(N), .ADDR_W(AW), .DW(DW), .ACC_W(40), .THRESH('0), .LR_SHIFT(LRS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .train(train), .label(label),
    .busy(busy), .done(done), .y(y), .updated(updated),
    .w_ena(w_ena), .w_wr_rd(w_wr_rd), .w_addr(w_addr), .w_wdata(w_wdata), .w_rdata(w_rdata),
    .x_ena(x_ena), .x_addr(x_addr), .x_rdata(x_rdata)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] wmem [2**AW];
  logic signed [DW-1:0] xmem [2**AW];
  logic signed [DW-1:0] w_init [2**AW];
  logic signed [DW-1:0] x_init [2**AW];
  logic ld = 1'b0;
  int   edge_n = 0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (ld) begin
      wmem <= w_init;
      xmem <= x_init;
    end else begin
      if (w_ena) begin
        if (w_wr_rd) wmem[w_addr] <= w_wdata;
        else         w_rdata      <= wmem[w_addr];
      end
      if (x_ena) x_rdata <= xmem[x_addr];
    end
  end

  typedef struct { int addr; int data; } wr_t;
  typedef struct { bit y; bit upd; int lat; } res_t;
  wr_t  wr_q [$];
  res_t res_q [$];

  int n_chk = 0, n_err = 0, n_wr = 0, n_done = 0, st_edge = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d exp %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] s16(input int v);
    return DW'(v);
  endfunction

  function automatic longint model_acc();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(wmem[i]) * longint'(xmem[i]);
    return s;
  endfunction

  task automatic load();
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Queue expected results from the current memory contents, then pulse start.
  task automatic launch(input bit tr, input bit lb);
    longint a;
    bit yy, up;
    int xs, v;
    res_t r;
    wr_t w;
    a  = model_acc();
    yy = (a >= 0);
    up = tr && (yy != lb);
    r.y = yy; r.upd = up; r.lat = up ? 3*N + 3 : N + 3;
    res_q.push_back(r);
    if (up) begin
      for (int i = 0; i < N; i++) begin
        xs = int'(xmem[i]) >>> LRS;
        v  = lb ? int'(wmem[i]) + xs : int'(wmem[i]) - xs;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        w.addr = i; w.data = v;
        wr_q.push_back(w);
      end
    end
    train = tr; label = lb; start = 1'b1;
    st_edge = edge_n + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string tag);
    for (int k = 0; k < 1000 && n_done == n0; k++) @(posedge clk);
    chk(tag, n_done - n0, 1);
    @(negedge clk);
  endtask

  task automatic fill(input int wv, input int xv);
    for (int i = 0; i < 2**AW; i++) begin
      w_init[i] = s16(wv);
      x_init[i] = s16(xv);
    end
  endtask

  initial begin
    fork
      forever begin : monitor
        wr_t  e;
        res_t r;
        @(negedge clk);
        if (rst_n) begin
          chk("mem_when_idle", (w_ena | x_ena | w_wr_rd) & ~busy, 0);
          chk("wr_with_xena", w_wr_rd & x_ena, 0);
          if (w_ena && w_wr_rd) begin
            chk("wr_pending", int'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
              e = wr_q.pop_front();
              chk("wr_addr", w_addr, e.addr);
              chk("wr_data", $signed(w_wdata), e.data);
            end
            n_wr++;
          end
          if (done) begin
            chk("res_pending", int'(res_q.size() != 0), 1);
            if (res_q.size() != 0) begin
              r = res_q.pop_front();
              chk("y", y, r.y);
              chk("updated", updated, r.upd);
              chk("latency", edge_n - st_edge, r.lat);
            end
            n_done++;
          end
        end
      end
      begin : stim
        int n0, w0, bad, got;
        bit yy;
        // reset held with start high
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("rst_busy", busy, 0);
          chk("rst_ena", w_ena | x_ena, 0);
        end
        chk("rst_done", done, 0);
        chk("rst_y", y, 0);
        chk("rst_upd", updated, 0);
        chk("rst_wr", w_wr_rd, 0);
        chk("rst_waddr", w_addr, 0);
        chk("rst_xaddr", x_addr, 0);
        chk("rst_wdata", w_wdata, 0);
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // inference, all 1.0 * 1.0
        fill(512, 512); load();
        n0 = n_done; w0 = n_wr;
        launch(1'b0, 1'b0);
        wait_done(n0, "t2_done");
        chk("t2_writes", n_wr - w0, 0);
        chk("t2_y", y, 1);
        chk("t2_upd", updated, 0);

        // training on error
        fill(-512, 512); load();
        n0 = n_done; w0 = n_wr;
        launch(1'b1, 1'b1);
        wait_done(n0, "t3_done");
        chk("t3_writes", n_wr - w0, N);
        bad = 0;
        for (int i = 0; i < N; i++) if (wmem[i] != -480) bad++;
        chk("t3_wmem", bad, 0);
        chk("t3_y", y, 0);
        chk("t3_upd", updated, 1);

        // positive saturation
        fill(-32768, 32767); w_init[5] = s16(32760); load();
        n0 = n_done;
        launch(1'b1, 1'b1);
        wait_done(n0, "t4a_done");
        chk("sat_hi", wmem[5], 32767);
        chk("t4a_upd", updated, 1);

        // negative saturation
        fill(32767, 32767); w_init[5] = s16(-32760); load();
        n0 = n_done;
        launch(1'b1, 1'b0);
        wait_done(n0, "t4b_done");
        chk("sat_lo", wmem[5], -32768);
        chk("t4b_y", y, 1);

        // correct classification in training mode, stray starts
        fill(512, 512); load();
        n0 = n_done; w0 = n_wr;
        launch(1'b1, 1'b1);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (done) begin got = 1; break; end
        end
        chk("t5_done_seen", got, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
          chk("t5_idle", busy, 0);
          @(negedge clk);
        end
        chk("t5_ndone", n_done - n0, 1);
        chk("t5_writes", n_wr - w0, 0);
        chk("t5_y", y, 1);

        // reset during the update of weight 20
        fill(-512, 512); load();
        w0 = n_wr;
        launch(1'b1, 1'b1);
        for (int k = 0; k < 2000; k++) begin
          @(posedge clk);
          if (n_wr - w0 >= 20) break;
        end
        chk("t6_reached", n_wr - w0, 20);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_ena", w_ena | x_ena | w_wr_rd, 0);
        rst_n = 1'b1;
        wr_q.delete();
        res_q.delete();
        bad = 0;
        for (int i = 0; i < N; i++) if (wmem[i] != ((i < 20) ? -480 : -512)) bad++;
        chk("t6_wmem", bad, 0);
        n0 = n_done; w0 = n_wr;
        launch(1'b1, 1'b1);
        wait_done(n0, "t6_rerun_done");
        chk("t6_writes", n_wr - w0, N);

        // random mixed-sign data, label chosen to force an update
        for (int t = 0; t < 2; t++) begin
          for (int i = 0; i < 2**AW; i++) begin
            w_init[i] = s16(int'($urandom_range(4000)) - 2000);
            x_init[i] = s16(int'($urandom_range(4000)) - 2000);
          end
          load();
          yy = (model_acc() >= 0);
          n0 = n_done;
          launch(1'b1, !yy);
          wait_done(n0, "t7_done");
          chk("t7_upd", updated, 1);
        end

        repeat (3) @(negedge clk);
        chk("left_writes", wr_q.size(), 0);
        chk("left_results", res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
      end
    join
  end

endmodule
